// File: rtl/sub_pkg.sv
// Shared types and helpers for the multi-cycle subtractor/comparator.
package sub_pkg;
  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CHUNK_DEF = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Signed overflow of a - b: operands differ in sign and result sign follows b.
  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit borrow-ripple subtract slice.
module sub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);
  logic [CHUNK:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_subtractor u_fs (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (brw[i]),
      .d    (d[i]),
      .bout (brw[i+1])
    );
  end

  assign bout = brw[CHUNK];
endmodule

// File: rtl/sub_multicycle.sv
// Multi-cycle subtractor/comparator: CHUNK bits per clock, LSB chunk first.
//   state | meaning
//   IDLE  | ready for operands
//   RUN   | one slice per cycle, borrow carried in brw_q
//   DONE  | result and flags held until ready_i
module sub_multicycle
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] d_o,
  output logic             borrow_o,
  output logic             zero_o,
  output logic             ltu_o,
  output logic             lt_o,
  output logic             ovf_o
);
  localparam int unsigned CHUNK_SAFE = (CHUNK == 0) ? 1 : CHUNK;
  localparam int unsigned NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int unsigned CNT_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK == 0) || (CHUNK > WIDTH) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_params
    $error("sub_multicycle: CHUNK must be nonzero and divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic             brw_q, brw_d, zacc_q, zacc_d;
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             valid_q, valid_d, borrow_q, borrow_d, zero_q, zero_d;
  logic             ltu_q, ltu_d, lt_q, lt_d, ovf_q, ovf_d;

  logic [CHUNK-1:0] slice_d;
  logic             slice_bout;

  sub_chunk #(.CHUNK(CHUNK)) u_slice (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .bin  (brw_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    brw_d    = brw_q;
    zacc_d   = zacc_q;
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    valid_d  = valid_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ltu_d    = ltu_q;
    lt_d     = lt_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          brw_d   = borrow_i;
          amsb_d  = a_i[WIDTH-1];
          bmsb_d  = b_i[WIDTH-1];
          cnt_d   = '0;
          zacc_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> CHUNK;
        b_d    = b_q >> CHUNK;
        d_d    = (d_q >> CHUNK) | (WIDTH'(slice_d) << (WIDTH - CHUNK));
        brw_d  = slice_bout;
        zacc_d = zacc_q & (slice_d == '0);
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          // The last slice holds the result MSB, so flags resolve here.
          state_d  = DONE;
          valid_d  = 1'b1;
          borrow_d = slice_bout;
          ltu_d    = slice_bout;
          zero_d   = zacc_d;
          ovf_d    = ovf_f(amsb_q, bmsb_q, slice_d[CHUNK-1]);
          lt_d     = slice_d[CHUNK-1] ^ ovf_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      brw_q    <= 1'b0;
      zacc_q   <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      valid_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ltu_q    <= 1'b0;
      lt_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      brw_q    <= brw_d;
      zacc_q   <= zacc_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      valid_q  <= valid_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ltu_q    <= ltu_d;
      lt_q     <= lt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Gated with rst_ni so the block never advertises readiness while held in reset.
  assign ready_o  = rst_ni && (state_q == IDLE);
  assign valid_o  = valid_q;
  assign d_o      = d_q;
  assign borrow_o = borrow_q;
  assign zero_o   = zero_q;
  assign ltu_o    = ltu_q;
  assign lt_o     = lt_q;
  assign ovf_o    = ovf_q;
endmodule
